// File: rtl/easyaxi_rd_arb.sv
// Two-master AXI read arbiter: round-robin locked AR grant (master index prepended to ARID), R routed by RID MSB.
// Latency: AR one cycle from arvalid to s_arvalid (max 1 AR per 2 cycles); R combinational, zero latency.
// Backpressure: s_arready reaches only the granted master; s_rready follows the routed master. Macro EASYAXI_RD_ARB_OST_LIMIT_EN gates eligibility on outstanding count.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
    parameter int OST_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m0_arvalid,
    output logic                      m0_arready,
    input  logic [`AXI_ID_W-1:0]      m0_arid,
    input  logic [`AXI_ADDR_W-1:0]    m0_araddr,
    input  logic [`AXI_LEN_W-1:0]     m0_arlen,
    input  logic [`AXI_SIZE_W-1:0]    m0_arsize,
    input  logic [`AXI_BURST_W-1:0]   m0_arburst,
    input  logic                      m1_arvalid,
    output logic                      m1_arready,
    input  logic [`AXI_ID_W-1:0]      m1_arid,
    input  logic [`AXI_ADDR_W-1:0]    m1_araddr,
    input  logic [`AXI_LEN_W-1:0]     m1_arlen,
    input  logic [`AXI_SIZE_W-1:0]    m1_arsize,
    input  logic [`AXI_BURST_W-1:0]   m1_arburst,
    output logic                      m0_rvalid,
    input  logic                      m0_rready,
    output logic [`AXI_ID_W-1:0]      m0_rid,
    output logic [`AXI_DATA_W-1:0]    m0_rdata,
    output logic [`AXI_RESP_W-1:0]    m0_rresp,
    output logic                      m0_rlast,
    output logic                      m1_rvalid,
    input  logic                      m1_rready,
    output logic [`AXI_ID_W-1:0]      m1_rid,
    output logic [`AXI_DATA_W-1:0]    m1_rdata,
    output logic [`AXI_RESP_W-1:0]    m1_rresp,
    output logic                      m1_rlast,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [`AXI_ID_W:0]        s_arid,
    output logic [`AXI_ADDR_W-1:0]    s_araddr,
    output logic [`AXI_LEN_W-1:0]     s_arlen,
    output logic [`AXI_SIZE_W-1:0]    s_arsize,
    output logic [`AXI_BURST_W-1:0]   s_arburst,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [`AXI_ID_W:0]        s_rid,
    input  logic [`AXI_DATA_W-1:0]   s_rdata,
    input  logic [`AXI_RESP_W-1:0]    s_rresp,
    input  logic                      s_rlast,
    output logic                      idle
);
    localparam int OST_CNT_W = $clog2(OST_MAX + 1);
    localparam logic [OST_CNT_W-1:0] OST_FULL = OST_CNT_W'(OST_MAX);
    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_GNT  = 1'b1;

    logic                 state_r;
    logic                 gnt_idx_r;
    logic                 prio_r;
    logic [OST_CNT_W-1:0] ost0_r;
    logic [OST_CNT_W-1:0] ost1_r;
    logic                 elig0;
    logic                 elig1;
    logic                 pick;
    logic                 ar_hs;
    logic                 r_sel;
    logic                 r_last_hs;

`ifdef EASYAXI_RD_ARB_OST_LIMIT_EN
    assign elig0 = m0_arvalid & (ost0_r != OST_FULL);
    assign elig1 = m1_arvalid & (ost1_r != OST_FULL);
`else
    assign elig0 = m0_arvalid;
    assign elig1 = m1_arvalid;
`endif

    assign pick  = (elig0 & elig1) ? prio_r : elig1;
    assign ar_hs = s_arvalid & s_arready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ARB_IDLE;
            gnt_idx_r <= 1'b0;
            prio_r    <= 1'b0;
        end else if (state_r == ARB_IDLE) begin
            if (elig0 | elig1) begin
                state_r   <= ARB_GNT;
                gnt_idx_r <= pick;
            end
        end else if (ar_hs) begin
            state_r <= ARB_IDLE;
            prio_r  <= ~gnt_idx_r;
        end
    end

    // Payload is not registered: the granted master holds it stable until arready.
    assign s_arvalid  = (state_r == ARB_GNT);
    assign s_arid     = {gnt_idx_r, gnt_idx_r ? m1_arid : m0_arid};
    assign s_araddr   = gnt_idx_r ? m1_araddr  : m0_araddr;
    assign s_arlen    = gnt_idx_r ? m1_arlen   : m0_arlen;
    assign s_arsize   = gnt_idx_r ? m1_arsize  : m0_arsize;
    assign s_arburst  = gnt_idx_r ? m1_arburst : m0_arburst;
    assign m0_arready = s_arvalid & ~gnt_idx_r & s_arready;
    assign m1_arready = s_arvalid &  gnt_idx_r & s_arready;

    assign r_sel     = s_rid[`AXI_ID_W];
    assign m0_rvalid = s_rvalid & ~r_sel;
    assign m1_rvalid = s_rvalid &  r_sel;
    assign s_rready  = r_sel ? m1_rready : m0_rready;
    assign m0_rid    = s_rid[`AXI_ID_W-1:0];
    assign m1_rid    = s_rid[`AXI_ID_W-1:0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign r_last_hs = s_rvalid & s_rready & s_rlast;

    // Saturating in both directions; a decrement at zero is a protocol error and is dropped.
    function automatic logic [OST_CNT_W-1:0] ost_next(input logic [OST_CNT_W-1:0] cnt,
                                                      input logic inc, input logic dec);
        logic [OST_CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != OST_FULL)
            nxt = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            nxt = cnt - 1'b1;
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost0_r <= '0;
            ost1_r <= '0;
        end else begin
            ost0_r <= ost_next(ost0_r, ar_hs & ~gnt_idx_r, r_last_hs & ~r_sel);
            ost1_r <= ost_next(ost1_r, ar_hs &  gnt_idx_r, r_last_hs &  r_sel);
        end
    end

    assign idle = (state_r == ARB_IDLE) & ~m0_arvalid & ~m1_arvalid &
                  (ost0_r == '0) & (ost1_r == '0);

endmodule
